// File: rtl/bus_pkg.sv
// bus_pkg: shared bus state encoding, ctrl field positions and burst-length rule
package bus_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_WRITE, ST_READ} state_t;
  localparam int CTRL_WAIT = 0;
  localparam int CTRL_WE = 1;
  localparam int CTRL_BURST_LO = 2;
  localparam int CTRL_BURST_HI = 4;
  function automatic logic [3:0] burst_len(input logic [2:0] code);
    return {1'b0, code} + 4'd1;
  endfunction
endpackage

// File: rtl/bus_mem_slave_if.sv
// bus_mem_slave_if: request/ack bus bundle
// master drives addr_strobe/bus_in/ctrl_in; slave drives bus_out/bus_drive/ctrl_out/ready_out
interface bus_mem_slave_if #(
  parameter int BUS_WIDTH = 32,
  parameter int CTRL_WIDTH = 8
);
  logic addr_strobe;
  logic [BUS_WIDTH-1:0] bus_in;
  logic [CTRL_WIDTH-1:0] ctrl_in;
  logic [BUS_WIDTH-1:0] bus_out;
  logic bus_drive;
  logic [CTRL_WIDTH-1:0] ctrl_out;
  logic ready_out;
  modport master(output addr_strobe, bus_in, ctrl_in, input bus_out, bus_drive, ctrl_out, ready_out);
  modport slave(input addr_strobe, bus_in, ctrl_in, output bus_out, bus_drive, ctrl_out, ready_out);
endinterface

// File: rtl/bus_mem_slave_ram.sv
// bus_slave_ram: word RAM, synchronous write, asynchronous read, no reset
// ports: clk, we_i, addr_i, wdata_i -> rdata_o
module bus_slave_ram #(
  parameter int WIDTH = 32,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [2**AW];
  always_ff @(posedge clk)
    if (we_i) mem_q[addr_i] <= wdata_i;
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/bus_mem_slave.sv
// bus_mem_slave: memory-backed bus responder with programmable wait cycles and bursts
// ports: clk, rst_n (async active-low), bus (slave modport of bus_mem_slave_if)
module bus_mem_slave
  import bus_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int CTRL_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  bus_mem_slave_if.slave bus
);
  state_t state_q, state_d;
  logic [DEPTH_LOG2-1:0] base_q, base_d, addr;
  logic we_q, we_d;
  logic [3:0] len_q, len_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;
  logic wait_on;
  logic [BUS_WIDTH-1:0] rdata;
  logic unused_bits;
  assign unused_bits = ^{bus.bus_in[BUS_WIDTH-1:DEPTH_LOG2], bus.ctrl_in[CTRL_WIDTH-1:CTRL_BURST_HI+1],
                         bus.ctrl_in[CTRL_WAIT]};
  // burst address wraps naturally through the truncated add
  assign addr = base_q + DEPTH_LOG2'(beat_cnt_q);
  assign wait_on = state_q == ST_WAIT && wait_cnt_q < 4'(WAIT_CYCLES);
  bus_slave_ram #(.WIDTH(BUS_WIDTH), .AW(DEPTH_LOG2)) u_ram (
    .clk(clk),
    .we_i(state_q == ST_WRITE),
    .addr_i(addr),
    .wdata_i(bus.bus_in),
    .rdata_o(rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      base_q <= '0;
      we_q <= 1'b0;
      len_q <= '0;
      wait_cnt_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      we_q <= we_d;
      len_q <= len_d;
      wait_cnt_q <= wait_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    we_d = we_q;
    len_d = len_q;
    wait_cnt_d = wait_cnt_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE:
        if (bus.addr_strobe) begin
          base_d = bus.bus_in[DEPTH_LOG2-1:0];
          we_d = bus.ctrl_in[CTRL_WE];
          len_d = burst_len(bus.ctrl_in[CTRL_BURST_HI:CTRL_BURST_LO]);
          wait_cnt_d = '0;
          beat_cnt_d = '0;
          state_d = ST_WAIT;
        end
      ST_WAIT:
        if (wait_cnt_q == 4'(WAIT_CYCLES)) state_d = we_q ? ST_WRITE : ST_READ;
        else wait_cnt_d = wait_cnt_q + 4'd1;
      default: begin
        beat_cnt_d = beat_cnt_q + 4'd1;
        if (beat_cnt_q == len_q - 4'd1) state_d = ST_IDLE;
      end
    endcase
  end
  always_comb begin
    bus.ctrl_out = '0;
    bus.ctrl_out[CTRL_WAIT] = wait_on;
  end
  assign bus.bus_drive = state_q == ST_READ;
  assign bus.bus_out = state_q == ST_READ ? rdata : '0;
  assign bus.ready_out = state_q == ST_IDLE;
endmodule

// File: tb/tb_bus_mem_slave.sv
// tb_bus_mem_slave: randomized scoreboard bench for bus_mem_slave against an array memory model
module tb_bus_mem_slave;
  localparam int W = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bus_mem_slave_if bi();
  bus_mem_slave_if bi0();
  bus_mem_slave #(.WAIT_CYCLES(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bi));
  bus_mem_slave #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bi0));
  int tests = 0;
  int fails = 0;
  logic [31:0] mem [16];
  logic [31:0] wd [8];
  logic [31:0] exp_q [$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bi.bus_drive) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected read beat: got %h expected no beat", bi.bus_out);
        end else chk("read beat", bi.bus_out, exp_q.pop_front());
      end else chk("bus_out idle", bi.bus_out, 32'h0);
    end
  end
  task automatic xfer(input logic [31:0] addr, input bit we, input logic [2:0] code, input int spur, input int rst_at);
    int len, b, n;
    len = int'(code) + 1;
    b = int'(addr[3:0]);
    n = 0;
    while (!bi.ready_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bi.ready_out) begin
      tests++;
      fails++;
      $display("FAIL ready timeout: got 0 expected 1");
      return;
    end
    if (!we) for (int i = 0; i < len; i++) exp_q.push_back(mem[(b + i) % 16]);
    bi.addr_strobe = 1'b1;
    bi.bus_in = addr;
    bi.ctrl_in = {3'($urandom), code, we, 1'($urandom)};
    @(negedge clk);
    bi.addr_strobe = 1'b0;
    bi.bus_in = $urandom;
    for (int i = 0; i < W; i++) begin
      chk("wait high", bi.ctrl_out, 32'h1);
      chk("ready low in wait", bi.ready_out, 32'h0);
      @(negedge clk);
    end
    chk("wait low", bi.ctrl_out, 32'h0);
    chk("no drive in wait", bi.bus_drive, 32'h0);
    @(negedge clk);
    for (int k = 0; k < len; k++) begin
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("ready after async reset", bi.ready_out, 32'h1);
        chk("drive after async reset", bi.bus_drive, 32'h0);
        chk("ctrl after async reset", bi.ctrl_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (k == spur) begin
        bi.addr_strobe = 1'b1;
        bi.bus_in = $urandom;
        bi.ctrl_in = 8'($urandom);
      end
      if (we) begin
        bi.bus_in = wd[k];
        mem[(b + k) % 16] = wd[k];
      end
      chk("beat drive", bi.bus_drive, {31'h0, !we});
      chk("ready low in beat", bi.ready_out, 32'h0);
      chk("wait low in beat", bi.ctrl_out, 32'h0);
      @(negedge clk);
      bi.addr_strobe = 1'b0;
    end
    chk("ready after burst", bi.ready_out, 32'h1);
  endtask
  task automatic rand_wd();
    for (int i = 0; i < 8; i++) wd[i] = $urandom;
  endtask
  initial begin
    logic [31:0] d0;
    bi.addr_strobe = 1'b0;
    bi.bus_in = '0;
    bi.ctrl_in = '0;
    bi0.addr_strobe = 1'b0;
    bi0.bus_in = '0;
    bi0.ctrl_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset ready", bi.ready_out, 32'h1);
    chk("reset ctrl", bi.ctrl_out, 32'h0);
    chk("reset drive", bi.bus_drive, 32'h0);
    chk("reset bus_out", bi.bus_out, 32'h0);
    rand_wd();
    xfer(32'h0, 1'b1, 3'd7, -1, -1);
    rand_wd();
    xfer(32'h8, 1'b1, 3'd7, -1, -1);
    wd[0] = 32'hDEADBEEF;
    xfer(32'h5, 1'b1, 3'd0, -1, -1);
    xfer(32'h5, 1'b0, 3'd0, -1, -1);
    wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
    xfer(32'hE, 1'b1, 3'd3, -1, -1);
    xfer(32'hE, 1'b0, 3'd3, -1, -1);
    repeat (40) begin
      rand_wd();
      xfer($urandom, 1'($urandom), 3'($urandom), -1, -1);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end
    xfer($urandom, 1'b0, 3'd7, 2, -1);
    rand_wd();
    xfer(32'h3, 1'b1, 3'd7, -1, 3);
    @(negedge clk);
    xfer(32'h3, 1'b0, 3'd7, -1, -1);
    d0 = $urandom;
    bi0.addr_strobe = 1'b1;
    bi0.bus_in = 32'h3;
    bi0.ctrl_in = 8'b0000_0010;
    @(negedge clk);
    bi0.addr_strobe = 1'b0;
    chk("w0 no wait", bi0.ctrl_out, 32'h0);
    chk("w0 ready low", bi0.ready_out, 32'h0);
    @(negedge clk);
    bi0.bus_in = d0;
    chk("w0 beat no drive", bi0.bus_drive, 32'h0);
    @(negedge clk);
    chk("w0 ready after write", bi0.ready_out, 32'h1);
    bi0.addr_strobe = 1'b1;
    bi0.bus_in = 32'h3;
    bi0.ctrl_in = 8'b0000_0000;
    @(negedge clk);
    bi0.addr_strobe = 1'b0;
    chk("w0 read no wait", bi0.ctrl_out, 32'h0);
    chk("w0 no early drive", bi0.bus_drive, 32'h0);
    @(negedge clk);
    chk("w0 read drive at A+2", bi0.bus_drive, 32'h1);
    chk("w0 read data", bi0.bus_out, d0);
    chk("w0 wait in beat", bi0.ctrl_out, 32'h0);
    @(negedge clk);
    chk("w0 ready at A+3", bi0.ready_out, 32'h1);
    chk("w0 drive off", bi0.bus_drive, 32'h0);
    chk("w0 bus_out off", bi0.bus_out, 32'h0);
    repeat (3) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bus_mem_slave.md
# bus_mem_slave

Memory-backed responder for the shared 32-bit request/ack bus. It sits opposite the bus masters. It latches the address phase the arbiter/decoder steers to it and inserts a programmable number of wait cycles via the WAIT control bit. It then accepts a write burst into, or streams a read burst out of, a small word-addressed RAM. It is the default target for master-side bring-up and burst tests.

## Interface
- BUS_WIDTH, 32, data/address bus width
- CTRL_WIDTH, 8, control bus width
- DEPTH_LOG2, 4, log2 of RAM depth in words (16 words)
- WAIT_CYCLES, 2, wait cycles inserted before the first data beat (0..15)

Ports:
- clk  in  1  bus clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- addr_strobe  in  1  decoder-qualified one-cycle pulse; master's address is on bus_in this cycle
- bus_in  in  BUS_WIDTH  address (address phase), write data (write beats)
- ctrl_in  in  CTRL_WIDTH  master control: [4:2] burst code, [1] we, [0] unused
- bus_out  out  BUS_WIDTH  read data during read beats, else 0
- bus_drive  out  1  high exactly during read beats (bus mux select)
- ctrl_out  out  CTRL_WIDTH  {7'b0, wait}
- ready_out  out  1  high when idle and able to accept an address phase

## Operation
- States: IDLE, WAIT, WRITE, READ.
- IDLE:
  - ready_out=1, wait=0.
  - On addr_strobe, latch:
    - base = bus_in[DEPTH_LOG2-1:0] (upper address bits ignored)
    - we = ctrl_in[1]
    - len = ctrl_in[4:2]+1 (1..8 beats)
  - Clear wait_cnt and beat_cnt, then go to WAIT.
- WAIT:
  - wait=1 while wait_cnt < WAIT_CYCLES; wait_cnt increments each cycle.
  - In the cycle where wait_cnt == WAIT_CYCLES, wait=0. Next state is WRITE if we, else READ.
- WRITE:
  - Each cycle, RAM[(base+beat_cnt) mod 2^DEPTH_LOG2] <= bus_in and beat_cnt increments.
  - After beat len-1, go to IDLE.
- READ:
  - Each cycle, bus_drive=1 and bus_out = RAM[(base+beat_cnt) mod 2^DEPTH_LOG2] (combinational read); beat_cnt increments.
  - After beat len-1, go to IDLE.
- Address arithmetic wraps modulo RAM depth; a burst crossing the top word continues at word 0.
- addr_strobe outside IDLE is ignored: no relatch, no state change. The arbiter guarantees this does not occur, but the block must tolerate it.
- ctrl_in[0] is never used.

## Timing
- Reset values: bus_out=0, bus_drive=0, ctrl_out=0, ready_out=1, state=IDLE, counters=0. RAM contents are not reset.
- Reset asserted mid-burst returns the block to IDLE immediately (asynchronous). Partial write beats already committed remain in RAM.
- Let cycle A carry addr_strobe. Then:
  - wait=1 in cycles A+1 .. A+WAIT_CYCLES.
  - wait=0 in cycle A+1+WAIT_CYCLES.
  - Data beats occupy cycles A+2+WAIT_CYCLES .. A+1+WAIT_CYCLES+len.
- With WAIT_CYCLES=0, wait is never high and the first beat is at A+2.
- ready_out is low from A+1 through the last beat. It is high in the cycle after the last beat, so back-to-back transfers are allowed with one idle cycle.
- Write data is sampled at the rising edge ending each write-beat cycle. Read data is stable for the entire read-beat cycle.
- Outputs are decoded from registered state and counters only. No combinational path exists from bus_in or ctrl_in to any output.

## Structure
- Shared package bus_pkg holds:
  - state encoding
  - ctrl field positions (CTRL_WAIT=0, CTRL_WE=1, CTRL_BURST_LO=2, CTRL_BURST_HI=4)
  - burst-code-to-length rule
- Masters and arbiter also use bus_pkg.
- One sub-module, bus_slave_ram: 2^DEPTH_LOG2 x BUS_WIDTH, synchronous write and asynchronous read, no reset.
- FSM and counters live in bus_mem_slave.

## Test plan
- Reset then idle: after rst_n release, ready_out=1, ctrl_out=0, bus_drive=0, bus_out=0.
- Single write then read, WAIT_CYCLES=2:
  - Write: strobe with address 5, ctrl burst 000 and we=1. Expect wait high A+1..A+2 and low A+3. Word 0xDEADBEEF at A+4 is written to RAM[5].
  - Read: strobe at address 5 with we=0. Expect bus_drive and bus_out=0xDEADBEEF at A+4 only.
- Burst-4 write with wrap:
  - Write 1,2,3,4 at base 14 (burst code 011).
  - Read back burst-4 from base 14. Expect beats 1,2,3,4, showing RAM[14]=1, RAM[15]=2, RAM[0]=3, RAM[1]=4.
- WAIT_CYCLES=0 instance: wait never asserts. Single read beat occurs at A+2. ready_out is high again at A+3.
- Spurious strobe and reset mid-burst:
  - Pulse addr_strobe during a read burst-8. Expect no change: 8 beats complete.
  - Assert rst_n low at beat 3 of a write burst-8. Expect immediate IDLE and bus_drive=0; RAM holds beats 0–2 only.
